// File: rtl/mac_pe_param.sv
// -----------------------------------------------------------------------------
// mac_pe_param
//   Parametrised systolic processing element. Cells tile into an R x C array:
//   activations travel west->east, partial sums travel north->south, and
//   weights shift down the columns. The cell runs in one of two modes.
//   In weight-stationary (WS) mode it adds act*weight to the psum coming in
//   from the north. In output-stationary (OS) mode it accumulates locally and
//   then drains the column through a shift chain.
//
// Valid semantics (all streams): there is no backpressure. A *_valid bit
//   qualifies its data bus in the same cycle. Data on a bus whose valid is low
//   is don't-care. Every registered stream has exactly one cycle of latency.
//
// Ports
//   clock, reset      rising-edge clock; asynchronous active-low reset
//   instr             0 = WS, 1 = OS (ignored while act_in_valid=1)
//   w_in/_valid       weight from north, loaded into the shadow register
//   w_out/_valid      previous shadow weight forwarded south
//   w_swap_in/_out    shadow->active copy pulse, forwarded south one cycle later
//   act_in/_valid     activation from west; act_out/_valid forwarded east
//   psum_in/_valid    partial sum from north
//   psum_out/_valid   partial sum (WS) or drained accumulator (OS) to south
//   drain             OS: shift the accumulator chain one step south
//   ovf               sticky overflow flag, cleared only by reset
//   dbg_state         current mode (0 = WS, 1 = OS)
// -----------------------------------------------------------------------------
module mac_pe_param #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_in_valid,
    output logic [DATA_W-1:0] w_out,
    output logic              w_out_valid,
    input  logic              w_swap_in,
    output logic              w_swap_out,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_in_valid,
    output logic [DATA_W-1:0] act_out,
    output logic              act_out_valid,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_in_valid,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_out_valid,
    input  logic              drain,
    output logic              ovf,
    output logic              dbg_state
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;

    typedef enum logic {ST_WS = 1'b0, ST_OS = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shadow_w_q, shadow_w_d;
    logic [DATA_W-1:0]  active_w_q, active_w_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]  w_out_q, w_out_d;
    logic               w_out_valid_q, w_out_valid_d;
    logic               w_swap_out_q, w_swap_out_d;
    logic [DATA_W-1:0]  act_out_q, act_out_d;
    logic               act_out_valid_q, act_out_valid_d;
    logic [ACC_W-1:0]   psum_out_q, psum_out_d;
    logic               psum_out_valid_q, psum_out_valid_d;
    logic               ovf_q, ovf_d;

    // Operands are extended to the full product width first. The low PROD_W
    // bits of the unsigned product then equal the two's-complement product.
    logic              a_ext, w_ext, p_ext;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  prod_x;
    logic [ACC_W-1:0]  psum_in_eff;
    logic [ACC_W:0]    ws_res, acc_res;

    assign a_ext  = SIGNED ? act_in[DATA_W-1]     : 1'b0;
    assign w_ext  = SIGNED ? active_w_q[DATA_W-1] : 1'b0;
    assign prod   = {{DATA_W{a_ext}}, act_in} * {{DATA_W{w_ext}}, active_w_q};
    assign p_ext  = SIGNED ? prod[PROD_W-1] : 1'b0;
    assign prod_x = {{(SUM_W-PROD_W){p_ext}}, prod};
    assign psum_in_eff = psum_in_valid ? psum_in : '0;

    // The function returns {overflow, result}. The sum is formed one bit wider
    // than ACC_W. A signed result is out of range when its top two bits differ.
    // An unsigned result is out of range when the carry bit is set.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] p);
        logic [SUM_W-1:0] a_x;
        logic [SUM_W-1:0] sum;
        logic             o;
        logic [ACC_W-1:0] r;
        a_x = {(SIGNED ? a[ACC_W-1] : 1'b0), a};
        sum = a_x + p;
        o   = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        r   = sum[ACC_W-1:0];
        if (o && SATURATE) begin
            if (SIGNED) begin
                r = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                r = '1;
            end
        end
        return {o, r};
    endfunction

    assign ws_res  = sat_add(psum_in_eff, prod_x);
    assign acc_res = sat_add(acc_q, prod_x);

    always_comb begin
        state_d          = state_q;
        shadow_w_d       = shadow_w_q;
        active_w_d       = active_w_q;
        acc_d            = acc_q;
        psum_out_d       = psum_out_q;
        psum_out_valid_d = psum_out_valid_q;
        ovf_d            = ovf_q;

        // A mode change is accepted only between activation streams.
        case (state_q)
            ST_WS:   if (instr && !act_in_valid) state_d = ST_OS;
            ST_OS:   if (!instr && !act_in_valid && !drain) state_d = ST_WS;
            default: state_d = ST_WS;
        endcase

        // The swap reads the pre-edge shadow, so a simultaneous load is not seen.
        if (w_in_valid) shadow_w_d = w_in;
        if (w_swap_in)  active_w_d = shadow_w_q;
        w_out_d         = shadow_w_q;
        w_out_valid_d   = w_in_valid;
        w_swap_out_d    = w_swap_in;
        act_out_d       = act_in;
        act_out_valid_d = act_in_valid;

        // psum_out is loaded only when the next valid is high. Otherwise it holds.
        if (state_q == ST_WS) begin
            if (act_in_valid) begin
                psum_out_d       = ws_res[ACC_W-1:0];
                psum_out_valid_d = 1'b1;
                if (ws_res[ACC_W]) ovf_d = 1'b1;
            end else begin
                psum_out_valid_d = psum_in_valid;
                if (psum_in_valid) psum_out_d = psum_in;
            end
        end else begin
            if (drain) begin
                // The accumulator moves south and the northern value takes its
                // place. A product that arrives in the same cycle is discarded.
                psum_out_d       = acc_q;
                psum_out_valid_d = 1'b1;
                acc_d            = psum_in_eff;
            end else begin
                psum_out_valid_d = psum_in_valid;
                if (psum_in_valid) psum_out_d = psum_in;
                if (act_in_valid) begin
                    acc_d = acc_res[ACC_W-1:0];
                    if (acc_res[ACC_W]) ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_WS;
            shadow_w_q       <= '0;
            active_w_q       <= '0;
            acc_q            <= '0;
            w_out_q          <= '0;
            w_out_valid_q    <= 1'b0;
            w_swap_out_q     <= 1'b0;
            act_out_q        <= '0;
            act_out_valid_q  <= 1'b0;
            psum_out_q       <= '0;
            psum_out_valid_q <= 1'b0;
            ovf_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            shadow_w_q       <= shadow_w_d;
            active_w_q       <= active_w_d;
            acc_q            <= acc_d;
            w_out_q          <= w_out_d;
            w_out_valid_q    <= w_out_valid_d;
            w_swap_out_q     <= w_swap_out_d;
            act_out_q        <= act_out_d;
            act_out_valid_q  <= act_out_valid_d;
            psum_out_q       <= psum_out_d;
            psum_out_valid_q <= psum_out_valid_d;
            ovf_q            <= ovf_d;
        end
    end

    assign w_out          = w_out_q;
    assign w_out_valid    = w_out_valid_q;
    assign w_swap_out     = w_swap_out_q;
    assign act_out        = act_out_q;
    assign act_out_valid  = act_out_valid_q;
    assign psum_out       = psum_out_q;
    assign psum_out_valid = psum_out_valid_q;
    assign ovf            = ovf_q;
    assign dbg_state      = (state_q == ST_OS);

endmodule

// File: tb/tb_mac_pe_param.sv
// Directed bench for mac_pe_param. One default cell (32-bit, signed, wrapping)
// and two 16-bit cells (saturating / wrapping) share the same stimulus.
module tb_mac_pe_param;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr = 1'b0;
    logic [7:0]  w_in = '0;
    logic        w_in_valid = 1'b0;
    logic        w_swap_in = 1'b0;
    logic [7:0]  act_in = '0;
    logic        act_in_valid = 1'b0;
    logic [31:0] psum_in = '0;
    logic        psum_in_valid = 1'b0;
    logic        drain = 1'b0;

    // default cell outputs
    logic [7:0]  w_out, act_out;
    logic        w_out_valid, w_swap_out, act_out_valid, psum_out_valid, ovf, dbg_state;
    logic [31:0] psum_out;
    // 16-bit saturating cell outputs
    logic [7:0]  s_w_out, s_act_out;
    logic        s_w_out_valid, s_w_swap_out, s_act_out_valid, s_psum_out_valid, s_ovf, s_dbg_state;
    logic [15:0] s_psum_out;
    // 16-bit wrapping cell outputs
    logic [7:0]  r_w_out, r_act_out;
    logic        r_w_out_valid, r_w_swap_out, r_act_out_valid, r_psum_out_valid, r_ovf, r_dbg_state;
    logic [15:0] r_psum_out;

    int n_checks = 0;
    int n_bad    = 0;
    logic [31:0] exp_q[$];

    mac_pe_param #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0)) u_dut (
        .clock(clock), .reset(reset), .instr(instr),
        .w_in(w_in), .w_in_valid(w_in_valid), .w_out(w_out), .w_out_valid(w_out_valid),
        .w_swap_in(w_swap_in), .w_swap_out(w_swap_out),
        .act_in(act_in), .act_in_valid(act_in_valid), .act_out(act_out), .act_out_valid(act_out_valid),
        .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_out(psum_out), .psum_out_valid(psum_out_valid),
        .drain(drain), .ovf(ovf), .dbg_state(dbg_state)
    );

    mac_pe_param #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1)) u_sat16 (
        .clock(clock), .reset(reset), .instr(instr),
        .w_in(w_in), .w_in_valid(w_in_valid), .w_out(s_w_out), .w_out_valid(s_w_out_valid),
        .w_swap_in(w_swap_in), .w_swap_out(s_w_swap_out),
        .act_in(act_in), .act_in_valid(act_in_valid), .act_out(s_act_out), .act_out_valid(s_act_out_valid),
        .psum_in(psum_in[15:0]), .psum_in_valid(psum_in_valid), .psum_out(s_psum_out),
        .psum_out_valid(s_psum_out_valid), .drain(drain), .ovf(s_ovf), .dbg_state(s_dbg_state)
    );

    mac_pe_param #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap16 (
        .clock(clock), .reset(reset), .instr(instr),
        .w_in(w_in), .w_in_valid(w_in_valid), .w_out(r_w_out), .w_out_valid(r_w_out_valid),
        .w_swap_in(w_swap_in), .w_swap_out(r_w_swap_out),
        .act_in(act_in), .act_in_valid(act_in_valid), .act_out(r_act_out), .act_out_valid(r_act_out_valid),
        .psum_in(psum_in[15:0]), .psum_in_valid(psum_in_valid), .psum_out(r_psum_out),
        .psum_out_valid(r_psum_out_valid), .drain(drain), .ovf(r_ovf), .dbg_state(r_dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_weight(input logic [7:0] w);
        w_in = w; w_in_valid = 1'b1; w_swap_in = 1'b0;
        step();
        w_in_valid = 1'b0; w_swap_in = 1'b1;
        step();
        w_swap_in = 1'b0;
    endtask

    task automatic send_act(input logic [7:0] a);
        act_in = a; act_in_valid = 1'b1;
        step();
        act_in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_psum", psum_out, 32'h0);
        check_eq("rst_psum_v", {31'b0, psum_out_valid}, 32'h0);
        check_eq("rst_act_v", {31'b0, act_out_valid}, 32'h0);
        check_eq("rst_state", {31'b0, dbg_state}, 32'h0);
        check_eq("rst_ovf", {31'b0, ovf}, 32'h0);
        reset = 1'b1;

        // T1: weight 3, act 5, psum 10 -> 25
        w_in = 8'd3; w_in_valid = 1'b1;
        step();
        check_eq("t1_wout_v", {31'b0, w_out_valid}, 32'h1);
        w_in_valid = 1'b0; w_swap_in = 1'b1;
        step();
        check_eq("t1_swap_out", {31'b0, w_swap_out}, 32'h1);
        check_eq("t1_wout", {24'b0, w_out}, 32'd3);
        w_swap_in = 1'b0;
        act_in = 8'd5; act_in_valid = 1'b1; psum_in = 32'd10; psum_in_valid = 1'b1;
        step();
        check_eq("t1_psum", psum_out, 32'd25);
        check_eq("t1_psum_v", {31'b0, psum_out_valid}, 32'h1);
        check_eq("t1_act", {24'b0, act_out}, 32'd5);
        act_in_valid = 1'b0; psum_in_valid = 1'b0;

        // T2: signed 7 * -2 with no incoming psum
        load_weight(8'd7);
        send_act(8'hFE);
        check_eq("t2_psum", psum_out, 32'hFFFF_FFF2);
        check_eq("t2_psum16", {16'b0, r_psum_out}, 32'h0000_FFF2);
        check_eq("t2_ovf16", {31'b0, s_ovf}, 32'h0);

        // T3: 32760 + 10 at 16 bits
        load_weight(8'd1);
        act_in = 8'd10; act_in_valid = 1'b1; psum_in = 32'd32760; psum_in_valid = 1'b1;
        step();
        act_in_valid = 1'b0; psum_in_valid = 1'b0;
        check_eq("t3_sat_psum", {16'b0, s_psum_out}, 32'h0000_7FFF);
        check_eq("t3_sat_ovf", {31'b0, s_ovf}, 32'h1);
        check_eq("t3_wrap_psum", {16'b0, r_psum_out}, 32'h0000_8002);
        check_eq("t3_wrap_ovf", {31'b0, r_ovf}, 32'h1);
        check_eq("t3_wide_psum", psum_out, 32'd32770);
        check_eq("t3_wide_ovf", {31'b0, ovf}, 32'h0);

        // T4: load and swap in the same cycle
        load_weight(8'd2);
        w_in = 8'd4; w_in_valid = 1'b1;
        step();
        w_in = 8'd9; w_in_valid = 1'b1; w_swap_in = 1'b1;
        step();
        check_eq("t4_wout_old", {24'b0, w_out}, 32'd4);
        w_in_valid = 1'b0; w_swap_in = 1'b0;
        send_act(8'd1);
        check_eq("t4_psum", psum_out, 32'd4);
        check_eq("t4_wout_new", {24'b0, w_out}, 32'd9);

        // T5: OS accumulate then drain chain
        instr = 1'b1;
        step();
        check_eq("t5_state", {31'b0, dbg_state}, 32'h1);
        load_weight(8'd2);
        for (int i = 1; i <= 4; i++) send_act(i[7:0]);
        check_eq("t5_acc_hidden_v", {31'b0, psum_out_valid}, 32'h0);
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd7);
        drain = 1'b1; psum_in = 32'd7; psum_in_valid = 1'b1;
        step();
        psum_in_valid = 1'b0;
        check_eq("t5_drain1", psum_out, exp_q.pop_front());
        check_eq("t5_drain1_v", {31'b0, psum_out_valid}, 32'h1);
        step();
        check_eq("t5_drain2", psum_out, exp_q.pop_front());
        check_eq("t5_drain2_v", {31'b0, psum_out_valid}, 32'h1);
        drain = 1'b0;
        step();
        check_eq("t5_drain_end_v", {31'b0, psum_out_valid}, 32'h0);

        // T6: asynchronous reset while accumulating in OS
        for (int i = 1; i <= 4; i++) send_act(i[7:0]);
        act_in = 8'd5; act_in_valid = 1'b1;
        step();
        check_eq("t6_act_v_pre", {31'b0, act_out_valid}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check_eq("t6_act_v", {31'b0, act_out_valid}, 32'h0);
        check_eq("t6_act", {24'b0, act_out}, 32'h0);
        check_eq("t6_psum", psum_out, 32'h0);
        check_eq("t6_state", {31'b0, dbg_state}, 32'h0);
        check_eq("t6_ovf16", {31'b0, s_ovf}, 32'h0);
        #1 reset = 1'b1;
        act_in_valid = 1'b0; instr = 1'b0; drain = 1'b1; psum_in_valid = 1'b0;
        step();
        check_eq("t6_drain_v", {31'b0, psum_out_valid}, 32'h0);
        check_eq("t6_state_after", {31'b0, dbg_state}, 32'h0);
        drain = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
